counter_controller: RTL
=======================

Name: counter_controller

Overview:
- Sequencing FSM for the 16-bit counter datapath (register C, ±1 adder/subtractor, zero/limit comparators).
- Drives the datapath control lines `op`, `c_ld` and `c_clr`, and consumes the status flags `z` and `m`.
- Supports one-shot count-up, one-shot count-down, and continuous bounce (up/down) modes.
- A programmable prescaler sets the step rate; pause and abort are supported.

Parameters:
- PRESCALE, 1, clock cycles per count step (≥1). 1 = step every cycle.
- PS_W, $clog2(PRESCALE+1), prescaler counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE only.
- dir  in  1  start direction: 0 = up, 1 = down; sampled with start.
- mode  in  1  0 = one-shot, 1 = bounce; sampled with start.
- pause  in  1  level; freezes counting while high.
- abort  in  1  level; returns to IDLE from any state.
- z  in  1  datapath status: C == 0.
- m  in  1  datapath status: C at upper limit.
- op  out  1  to datapath: 0 = C+1, 1 = C−1.
- c_ld  out  1  to datapath: load next C at the coming edge.
- c_clr  out  1  to datapath: clear C at the coming edge.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  one-cycle pulse when a one-shot run completes.
- state_out  out  3  current state encoding, for debug.

Behaviour:
- Reset (reset=0, async):
  - state = IDLE; prescaler = 0; saved direction = 0.
  - All outputs 0: op, c_ld, c_clr, busy, done.
- States: IDLE=0, CLR=1, UP=2, DOWN=3, PAUSED=4, DONE=5. Codes 6 and 7 are illegal and return to IDLE on the next cycle.
- IDLE:
  - start=1, dir=0 → CLR.
  - start=1, dir=1 → DOWN, counting from the current C.
  - abort=1 has priority over start: stay in IDLE.
- CLR:
  - c_clr=1 for exactly 1 cycle, then → UP.
  - Prescaler reset to 0.
- UP:
  - op=0.
  - tick = (prescaler == PRESCALE−1); prescaler wraps to 0 on tick.
  - c_ld = tick AND NOT m.
  - If m=1: one-shot → DONE; bounce → DOWN with prescaler reset. No load in that cycle.
- DOWN:
  - op=1; tick and prescaler as in UP.
  - c_ld = tick AND NOT z.
  - If z=1: one-shot → DONE; bounce → UP with prescaler reset.
  - DOWN entered with C already 0 → DONE on the next edge with zero loads.
- Flag timing:
  - z and m reflect the current C and are evaluated combinationally in the same cycle.
  - c_ld is never asserted while the terminal flag for the current direction is high, so C never wraps (no 0xFFFF↔0 wrap-around).
- PAUSED:
  - pause=1 in UP/DOWN → PAUSED; the direction is saved and the prescaler value is held.
  - c_ld is forced to 0 in the cycle pause is seen.
  - pause=0 → return to the saved direction; the prescaler resumes from its held value.
- DONE:
  - done=1 for 1 cycle, then → IDLE.
  - start in DONE is ignored.
- Abort:
  - abort=1 in any non-IDLE state → IDLE on the next edge.
  - c_ld and c_clr are gated to 0 combinationally in the same cycle.
  - No done pulse; C is left at its value.
- Priority in UP/DOWN: abort > pause > terminal flag > tick.
- Outputs are Moore-style decodes of state and prescaler; the only input terms are the z/m/pause/abort gating described above.
- op holds its last direction value in IDLE, PAUSED and DONE (don't-care to the datapath, but stable).
- busy = state ∈ {CLR, UP, DOWN, PAUSED}.

Decomposition:
- Shared package:
  - State encoding localparams (ST_IDLE … ST_DONE).
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - DIR_UP/DIR_DOWN and MODE_ONESHOT/MODE_BOUNCE constants.
- One sub-module: prescale_tick.
  - Parameterised by PRESCALE.
  - Inputs: enable, restart. Output: tick.
  - Async active-low reset.
- FSM, output decode and gating stay in counter_controller.
- Top level: counter_controller wired to the datapath via op/c_ld/c_clr/z/m.

Test Plan:
Common bench: PRESCALE=1 unless stated; behavioural C model with z=(C==0) and m=(C==5), updated from op/c_ld/c_clr.
1. One-shot up: start=1, dir=0, mode=0 →
   - c_clr for 1 cycle, then C steps 0→5 in 5 c_ld cycles.
   - No load while m=1; done pulses exactly once; busy falls.
   - C stays 5.
2. One-shot down from C=3: start=1, dir=1 →
   - op=1, 3 loads, C=0, done pulse.
   - Repeating the run at C=0 → done after 1 cycle with 0 loads.
3. Bounce: start=1, dir=0, mode=1 →
   - C sequence 0,1..5,4..0,1… with no done pulse.
   - After 2 full periods, abort=1 → IDLE next edge; c_ld=0 in the abort cycle.
4. PRESCALE=3, one-shot up →
   - c_ld high every 3rd cycle.
   - pause=1 for 4 cycles mid-run → no loads, state_out=4; resume keeps 3-cycle spacing from the held prescaler value.
   - Final C=5.
5. Simultaneous events:
   - start and abort together in IDLE → stays IDLE.
   - pause and abort together in UP → IDLE.
   - m=1 and tick in the same cycle → no load.
6. Reset mid-run:
   - Drive reset=0 asynchronously between edges during UP → all outputs 0 immediately and state_out=0.
   - Release reset, then start → normal run completes.

Source files
------------

// File: rtl/counter_controller_pkg.sv
// Shared encodings for the counter sequencing FSM and its datapath control lines.
package counter_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_UP     = 3'd2,
    ST_DOWN   = 3'd3,
    ST_PAUSED = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_BOUNCE  = 1'b1;

endpackage

// File: rtl/counter_controller_prescale_tick.sv
// Step-rate prescaler: tick is high while the count sits at PRESCALE-1.
// The count advances only when enabled, holds otherwise, and restart clears it.
module prescale_tick #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int unsigned PS_W = $clog2(PRESCALE + 1);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] count;

  assign tick = (count == LAST);

  // Prescaler count: clear on restart, wrap on tick, hold when not enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + PS_W'(1);
    end
  end

endmodule

// File: rtl/counter_controller.sv
// Sequencing FSM for the 16-bit counter datapath: one-shot up/down and bounce
// modes, prescaled step rate, pause and abort.
module counter_controller #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  input  logic       mode,
  input  logic       pause,
  input  logic       abort,
  input  logic       z,
  input  logic       m,
  output logic       op,
  output logic       c_ld,
  output logic       c_clr,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_out
);

  import counter_controller_pkg::*;

  state_t state, state_nx;
  logic   mode_q;
  logic   saved_dir;
  logic   tick;
  logic   counting;
  logic   term;
  logic   ps_enable;
  logic   ps_restart;

  assign counting = (state == ST_UP) || (state == ST_DOWN);
  // Terminal flag for the direction currently being counted.
  assign term     = (state == ST_DOWN) ? z : m;

  // The prescaler only advances on cycles that could actually step C; a
  // bounce turn-around restarts it so each direction begins a fresh period.
  assign ps_enable  = counting && !abort && !pause && !term;
  assign ps_restart = (state == ST_IDLE) || (state == ST_CLR) || (state == ST_DONE) ||
                      (counting && !abort && !pause && term);

  prescale_tick #(.PRESCALE(PRESCALE)) u_prescale (
    .clk     (clk),
    .reset   (reset),
    .enable  (ps_enable),
    .restart (ps_restart),
    .tick    (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Run mode captured at start; last counting direction kept for pause/resume and op hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= MODE_ONESHOT;
      saved_dir <= DIR_UP;
    end else begin
      if ((state == ST_IDLE) && start && !abort) begin
        mode_q <= mode;
      end
      if (state == ST_UP) begin
        saved_dir <= DIR_UP;
      end else if (state == ST_DOWN) begin
        saved_dir <= DIR_DOWN;
      end
    end
  end

  // Next-state logic; in UP/DOWN the priority is abort > pause > terminal flag.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (!abort && start) begin
          state_nx = (dir == DIR_DOWN) ? ST_DOWN : ST_CLR;
        end
      end
      ST_CLR: state_nx = abort ? ST_IDLE : ST_UP;
      ST_UP, ST_DOWN: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (pause) begin
          state_nx = ST_PAUSED;
        end else if (term) begin
          if (mode_q == MODE_BOUNCE) begin
            state_nx = (state == ST_UP) ? ST_DOWN : ST_UP;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_PAUSED: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (!pause) begin
          state_nx = (saved_dir == DIR_DOWN) ? ST_DOWN : ST_UP;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output decode; loads and clears are gated by abort/pause/terminal flag in the same cycle.
  always_comb begin
    op    = saved_dir;
    c_ld  = 1'b0;
    c_clr = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_CLR: begin
        busy  = 1'b1;
        c_clr = !abort;
      end
      ST_UP: begin
        busy = 1'b1;
        op   = OP_ADD;
        c_ld = tick && !m && !pause && !abort;
      end
      ST_DOWN: begin
        busy = 1'b1;
        op   = OP_SUB;
        c_ld = tick && !z && !pause && !abort;
      end
      ST_PAUSED: busy = 1'b1;
      ST_DONE:   done = 1'b1;
      default: ;
    endcase
  end

  assign state_out = state;

endmodule
